pal_fuse_loader: RTL
====================

# pal_fuse_loader

Serial fuse-map loader that sits directly upstream of the 3-input / 3-output PAL array and supplies its AND-plane configuration. It accepts a fuse bitstream one bit per handshake, checks an optional trailing 8-bit checksum, and commits the map atomically to a held parallel output. The PAL array consumes that output combinationally. A failed or aborted load never disturbs the previously committed map.

## Interface
- N_IN, 3, PAL inputs; each has a true and a complement literal
- N_OUT, 3, PAL outputs (OR terms)
- N_PT, 3, product terms per output
- FUSE_W, N_OUT*N_PT*2*N_IN (54), derived fuse count; not overridable
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- abort  in  1  cancel the load in progress
- ser_valid  in  1  serial bit offered
- ser_data  in  1  fuse or checksum bit, MSB first
- ser_ready  out  1  loader accepts a bit this cycle
- fuse_map  out  FUSE_W  committed fuse map to the PAL array
- map_valid  out  1  fuse_map holds a checked map
- busy  out  1  load in progress
- err  out  1  last load failed its checksum

## Operation
- Fuse index = ((out*N_PT + pt)*2*N_IN) + 2*in + neg. neg=1 selects the complement literal.
- Fuse=1 includes the literal in the product term. A term with no fuse set evaluates to 0 (unused term).
- States: IDLE, LOAD, CHECK, ERROR.
- IDLE: on start -> LOAD; clear staging register, bit counter and running popcount; clear err.
- LOAD: ser_ready=1. Each accepted bit (ser_valid & ser_ready) shifts into the staging register; the first bit lands at index FUSE_W-1. The popcount increments on a 1.
  - After FUSE_W accepts -> CHECK.
- CHECK: ser_ready=1. Accept 8 checksum bits, MSB first.
  - After the 8th accept, compare against popcount mod 256.
  - Match: copy staging to fuse_map, set map_valid, -> IDLE.
  - Mismatch: -> ERROR.
- ERROR: err=1, busy=0, ser_ready=0. Hold fuse_map and map_valid unchanged. start -> LOAD (clears err).
- abort in LOAD or CHECK: -> IDLE; discard staging; fuse_map, map_valid and err unchanged. abort has priority over a simultaneous accept.
- start while busy is ignored. start together with abort in IDLE: abort wins, stay IDLE.
- The bit counter is sized clog2(FUSE_W+8) and never wraps; it saturates into the state change.

## Timing
- Reset values: fuse_map=0, map_valid=0, busy=0, err=0, ser_ready=0, state IDLE. rst mid-load discards everything, including the committed map.
- busy and ser_ready rise the cycle after start is sampled.
- One bit per cycle maximum. ser_ready is a pure function of state (no ready-on-valid dependency).
- The last checksum accept at edge k gives fuse_map/map_valid update, busy=0 and ser_ready=0 after edge k+1.
- Minimum load = 1 + FUSE_W + 8 cycles (63 at defaults) with ser_valid held high.
- fuse_map changes only on a commit edge, so the PAL sees no partial map.

## Configuration
- PAL_LOADER_CHECKSUM_EN defined: the CHECK state and the 8-bit trailer exist as described.
- Undefined: no CHECK state and no popcount logic. Commit happens on the FUSE_W-th accept, and err is tied to 0.

## Structure
- Shared package pal_pkg holds:
  - N_IN/N_OUT/N_PT defaults
  - FUSE_W and CHK_W=8 constants
  - the state enum
  - a fuse_index(out,pt,in,neg) function shared with the PAL array.
- No sub-module; the FSM, shift register and popcount live in one module.

## Test plan
- Reset then idle: rst pulse -> fuse_map=0, map_valid=0, ser_ready=0. No accept while ser_valid=1 in IDLE.
- Good load: stream 54 bits with only index 2 set (out0/pt0 = b), checksum 8'h01 -> map_valid=1, fuse_map=54'h4. Commit lands exactly 1 cycle after the last accept.
- Bad checksum: same 54 bits, checksum 8'h02 -> err=1, map_valid and fuse_map keep their prior values. A new start clears err.
- Backpressure: ser_valid toggled every other cycle -> identical fuse_map to the back-to-back case, with the load taking 2x the cycles.
- Abort at bit 30 of a reload over committed map 54'h4 -> IDLE, fuse_map stays 54'h4, map_valid stays 1.
- Macro undefined: 54 bits, all ones -> commit on the 54th accept, fuse_map all ones, err never asserts.

Source files
------------

// File: rtl/pal_pkg.sv
// pal_pkg: shared constants, state encoding and fuse addressing for the
// 3-input / 3-output PAL array and its serial fuse loader.
//
// Contents:
//   N_IN, N_OUT, N_PT  - PAL geometry (inputs, outputs, product terms/output)
//   FUSE_W             - derived AND-plane fuse count (54 at defaults)
//   CHK_W              - width of the optional trailing checksum (8)
//   pal_state_e        - loader FSM state encoding
//   fuse_index()       - maps (out, pt, in, neg) to a bit position in fuse_map
package pal_pkg;

  localparam int N_IN   = 3;
  localparam int N_OUT  = 3;
  localparam int N_PT   = 3;
  localparam int FUSE_W = N_OUT * N_PT * 2 * N_IN;
  localparam int CHK_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } pal_state_e;

  // Each product term owns 2*N_IN consecutive fuses: true literal of input 0,
  // complement of input 0, true of input 1, ... neg=1 picks the complement.
  function automatic int fuse_index(input int out_i, input int pt_i,
                                    input int in_i, input int neg);
    return ((out_i * N_PT + pt_i) * 2 * N_IN) + 2 * in_i + neg;
  endfunction

endpackage

// File: rtl/pal_fuse_loader.sv
// pal_fuse_loader: serial fuse-map loader for the PAL AND plane.
//
// A load begins with a one-cycle start pulse. FUSE_W fuse bits then arrive
// MSB first, one per handshake, into a staging register. With the checksum
// build, an 8-bit trailer follows and must equal the popcount of the fuse
// bits (mod 256). Only a fully checked load is copied into fuse_map, so the
// PAL array never sees a partial or rejected map.
//
// Build option:
//   PAL_LOADER_CHECKSUM_EN - when defined, adds the CHECK/ERROR states, the
//                            popcount and the checksum trailer. When left
//                            undefined, the map commits on the FUSE_W-th
//                            accepted bit and err is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle request to begin a load (ignored while busy)
//   abort      in   cancel the load in progress, discarding staged bits
//   ser_valid  in   serial bit offered
//   ser_data   in   fuse or checksum bit, MSB first
//   ser_ready  out  loader accepts a bit this cycle
//   fuse_map   out  committed fuse map (FUSE_W bits) to the PAL array
//   map_valid  out  fuse_map holds a checked map
//   busy       out  load in progress
//   err        out  last load failed its checksum
//   dbg_state  out  current FSM state (pal_state_e encoding)
//
// Handshake: a bit transfers on a rising edge where ser_valid and ser_ready
// are both 1. ser_ready depends only on registered state, never on
// ser_valid; the source may hold ser_valid high for back-to-back bits and
// must keep ser_data stable while ser_valid is high and ser_ready is low.
module pal_fuse_loader
  import pal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ser_valid,
  input  logic              ser_data,
  output logic              ser_ready,
  output logic [FUSE_W-1:0] fuse_map,
  output logic              map_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
`ifdef PAL_LOADER_CHECKSUM_EN
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_ERROR = ST_ERROR;
`endif

  // Counts fuse bits, then continues through the checksum bits. It stops at
  // its last value and the state change takes over, so it never wraps.
  localparam int CNT_W = $clog2(FUSE_W + CHK_W);
  localparam logic [CNT_W-1:0] CNT_LAST_FUSE = CNT_W'(FUSE_W - 1);
`ifdef PAL_LOADER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FUSE_W + CHK_W);
`endif

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FUSE_W-1:0] staging;
  logic [FUSE_W-1:0] staging_next;
  logic              accept;

`ifdef PAL_LOADER_CHECKSUM_EN
  logic [CHK_W-1:0]  popcount;
  logic [CHK_W-1:0]  chk_sr;
`endif

  // First accepted bit ends up at index FUSE_W-1 after FUSE_W shifts.
  assign staging_next = {staging[FUSE_W-2:0], ser_data};

`ifdef PAL_LOADER_CHECKSUM_EN
  // In CHECK the loader stops accepting once all trailer bits are in; that
  // cycle is spent on the comparison before the commit edge.
  assign ser_ready = (state == S_LOAD) ||
                     ((state == S_CHECK) && (bit_cnt != CNT_FULL));
  assign busy      = (state == S_LOAD) || (state == S_CHECK);
  assign err       = (state == S_ERROR);
`else
  assign ser_ready = (state == S_LOAD);
  assign busy      = (state == S_LOAD);
  assign err       = 1'b0;
`endif

  // abort outranks a transfer offered in the same cycle.
  assign accept    = ser_valid && ser_ready && !abort;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      staging   <= '0;
      fuse_map  <= '0;
      map_valid <= 1'b0;
`ifdef PAL_LOADER_CHECKSUM_EN
      popcount  <= '0;
      chk_sr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state   <= S_LOAD;
            bit_cnt <= '0;
            staging <= '0;
`ifdef PAL_LOADER_CHECKSUM_EN
            popcount <= '0;
            chk_sr   <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (abort) begin
            state   <= S_IDLE;
            staging <= '0;
          end else if (accept) begin
            staging <= staging_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef PAL_LOADER_CHECKSUM_EN
            popcount <= popcount + {{(CHK_W-1){1'b0}}, ser_data};
            if (bit_cnt == CNT_LAST_FUSE) begin
              state <= S_CHECK;
            end
`else
            // No trailer: the last fuse bit goes straight into the commit.
            if (bit_cnt == CNT_LAST_FUSE) begin
              fuse_map  <= staging_next;
              map_valid <= 1'b1;
              state     <= S_IDLE;
            end
`endif
          end
        end

`ifdef PAL_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            state   <= S_IDLE;
            staging <= '0;
          end else if (bit_cnt == CNT_FULL) begin
            if (chk_sr == popcount) begin
              fuse_map  <= staging;
              map_valid <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERROR;
            end
          end else if (accept) begin
            chk_sr  <= {chk_sr[CHK_W-2:0], ser_data};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        S_ERROR: begin
          // Previous fuse_map/map_valid are left alone; only a new load
          // leaves this state.
          if (start) begin
            state    <= S_LOAD;
            bit_cnt  <= '0;
            staging  <= '0;
            popcount <= '0;
            chk_sr   <= '0;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
